// File: rtl/osd_scroll_src_if.sv
// Signal bundle between a pixel/command driver (master) and the OSD text source (slave).
// The OSD returns busy and the pixel color.
interface osd_scroll_src_if #(
  parameter int CD = 12,
  parameter int CW = 7,
  parameter int RW = 5
);
  logic [10:0]   x;
  logic [10:0]   y;
  logic [CW-1:0] xt;
  logic [RW-1:0] yt;
  logic [7:0]    ch_in;
  logic          we_ch;
  logic          clr_all;
  logic          scroll_up;
  logic          cur_en;
  logic [CW-1:0] xc;
  logic [RW-1:0] yc;
  logic [CD-1:0] front_rgb;
  logic [CD-1:0] back_rgb;
  logic          busy;
  logic [CD-1:0] osd_rgb;

  modport master (
    output x, y, xt, yt, ch_in, we_ch, clr_all, scroll_up,
           cur_en, xc, yc, front_rgb, back_rgb,
    input  busy, osd_rgb
  );

  modport slave (
    input  x, y, xt, yt, ch_in, we_ch, clr_all, scroll_up,
           cur_en, xc, yc, front_rgb, back_rgb,
    output busy, osd_rgb
  );
endinterface

// File: rtl/osd_scroll_src.sv
// Scrolling text-mode OSD: tile RAM plus font ROM, rendering 8x16 glyphs with a blinking cursor.
// Hardware scroll is a row offset, so a scroll only has to blank one physical row.
module osd_scroll_src #(
  parameter int          CD        = 12,
  parameter int unsigned KEY_COLOR = 0,
  parameter int          CW        = 7,
  parameter int          RW        = 5,
  parameter int          BLINK_W   = 25
) (
  input logic             clk,
  input logic             reset,
  osd_scroll_src_if.slave bus
);

  localparam int            AW        = CW + RW;
  localparam logic [CD-1:0] KEY       = CD'(KEY_COLOR);
  localparam logic [AW-1:0] LAST_CELL = '1;
  localparam logic [CW-1:0] LAST_COL  = '1;

  typedef enum logic [1:0] {
    IDLE,
    CLR_ALL,
    CLR_ROW
  } state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      sweep_q, sweep_d;
  logic [RW-1:0]      scroll_q, scroll_d;
  logic [RW-1:0]      clr_row_q, clr_row_d;
  logic [BLINK_W-1:0] blink_q;

  logic               ram_we;
  logic [AW-1:0]      ram_waddr;
  logic [7:0]         ram_wdata;
  logic [7:0]         tile_ram [0:(1<<AW)-1];

  logic [RW-1:0]      wr_row;
  logic [CW-1:0]      rd_col;
  logic [RW-1:0]      rd_lrow;
  logic [RW-1:0]      rd_prow;
  logic [AW-1:0]      rd_addr;
  logic               cursor_hit;

  logic [7:0]         ch_q;
  logic               hit_q;
  logic [2:0]         x_d1_q;
  logic [2:0]         x_d2_q;
  logic [3:0]         y_d1_q;
  logic [7:0]         font_q;
  logic               rev_q;
  logic               opaque_q;
  logic               font_bit;
  logic               unused_bits;

  // Glyph rows 0, 1 and 14, 15 are spacing; NULL is blank so a cursor on it shows a solid block.
  function automatic logic [7:0] fontRow(input logic [6:0] c, input logic [3:0] r);
    logic [7:0] row;
    row = 8'h00;
    if (c != 7'h00 && r >= 4'd2 && r <= 4'd13) begin
      if (c == 7'h41) begin
        case (r)
          4'd2:    row = 8'h10;
          4'd3:    row = 8'h38;
          4'd4:    row = 8'h6C;
          4'd7:    row = 8'hFE;
          4'd12,
          4'd13:   row = 8'h00;
          default: row = 8'hC6;
        endcase
      end else begin
        row = {c, r[0]};
      end
    end
    return row;
  endfunction

  assign wr_row  = bus.yt + scroll_q;
  assign rd_col  = bus.x[CW+2:3];
  assign rd_lrow = bus.y[RW+3:4];
  assign rd_prow = rd_lrow + scroll_q;
  assign rd_addr = {rd_prow, rd_col};

  assign unused_bits = ^{bus.x, bus.y};

  assign cursor_hit = bus.cur_en & blink_q[BLINK_W-1] &
                      (rd_col == bus.xc) & (rd_lrow == bus.yc);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sweep_q   <= '0;
      scroll_q  <= '0;
      clr_row_q <= '0;
      blink_q   <= '0;
    end else begin
      state_q   <= state_d;
      sweep_q   <= sweep_d;
      scroll_q  <= scroll_d;
      clr_row_q <= clr_row_d;
      blink_q   <= blink_q + 1'b1;
    end
  end

  // The sweep owns the single write port; host writes only get it in IDLE with no command pending.
  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    scroll_d  = scroll_q;
    clr_row_d = clr_row_q;
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = 8'h00;
    unique case (state_q)
      IDLE: begin
        if (bus.clr_all) begin
          state_d = CLR_ALL;
          sweep_d = '0;
        end else if (bus.scroll_up) begin
          state_d   = CLR_ROW;
          sweep_d   = '0;
          clr_row_d = scroll_q;
          scroll_d  = scroll_q + 1'b1;
        end else if (bus.we_ch) begin
          ram_we    = 1'b1;
          ram_waddr = {wr_row, bus.xt};
          ram_wdata = bus.ch_in;
        end
      end
      CLR_ALL: begin
        ram_we    = 1'b1;
        ram_waddr = sweep_q;
        sweep_d   = sweep_q + 1'b1;
        if (sweep_q == LAST_CELL) begin
          state_d = IDLE;
        end
      end
      CLR_ROW: begin
        ram_we    = 1'b1;
        ram_waddr = {clr_row_q, sweep_q[CW-1:0]};
        sweep_d   = sweep_q + 1'b1;
        if (sweep_q[CW-1:0] == LAST_COL) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (ram_we) begin
      tile_ram[ram_waddr] <= ram_wdata;
    end
  end

  // Stage 1 reads the tile, stage 2 reads the font; x and y low bits ride along to match.
  always_ff @(posedge clk) begin
    if (reset) begin
      ch_q     <= 8'h00;
      hit_q    <= 1'b0;
      x_d1_q   <= 3'd0;
      y_d1_q   <= 4'd0;
      x_d2_q   <= 3'd0;
      font_q   <= 8'h00;
      rev_q    <= 1'b0;
      opaque_q <= 1'b0;
    end else begin
      ch_q     <= tile_ram[rd_addr];
      hit_q    <= cursor_hit;
      x_d1_q   <= bus.x[2:0];
      y_d1_q   <= bus.y[3:0];
      x_d2_q   <= x_d1_q;
      font_q   <= fontRow(ch_q[6:0], y_d1_q);
      rev_q    <= ch_q[7] ^ hit_q;
      opaque_q <= (ch_q[6:0] != 7'h00) | hit_q;
    end
  end

  assign font_bit    = font_q[3'd7 - x_d2_q];
  assign bus.osd_rgb = !opaque_q ? KEY :
                       ((font_bit ^ rev_q) ? bus.front_rgb : bus.back_rgb);

endmodule

// File: doc/osd_scroll_src.md
OSD_SCROLL_SRC -- requirements
Module: osd_scroll_src

Interface
REQ-001 Parameter CD, default 12: color depth of all RGB ports.
REQ-002 Parameter KEY_COLOR, default 0: chroma-key value output for transparent pixels.
REQ-003 Parameter CW, default 7: tile column address bits, 2^CW columns; CW+3 <= 11.
REQ-004 Parameter RW, default 5: tile row address bits, 2^RW rows; RW+4 <= 11.
REQ-005 Parameter BLINK_W, default 25: cursor blink counter width.
REQ-006 clk  in  1  system clock; all state on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 x, y  in  11 each  current pixel coordinate.
REQ-009 xt  in  CW  and  yt  in  RW: logical tile write coordinate.
REQ-010 ch_in  in  8  character data (bit7 reverse, bits6:0 ASCII); we_ch  in  1  write strobe.
REQ-011 clr_all  in  1  one-cycle pulse, clear the whole tile RAM.
REQ-012 scroll_up  in  1  one-cycle pulse, scroll up one row and blank the new bottom row.
REQ-013 cur_en  in  1; xc  in  CW; yc  in  RW: cursor enable and logical cursor cell.
REQ-014 front_rgb, back_rgb  in  CD each  foreground/background color.
REQ-015 busy  out  1  high while a clear or scroll sweep runs.
REQ-016 osd_rgb  out  CD  pixel output.

Function
REQ-017 Tile RAM: 2^(CW+RW) x 8, synchronous read and write, one write port shared by we_ch and the sweep FSM. The font ROM (7-bit char, 4-bit row) is synchronous.
REQ-018 Read path: logical column = x[CW+2:3], logical row = y[RW+3:4], physical row = (logical row + scroll_reg) mod 2^RW. Read address = {physical row, column}.
REQ-019 Latency: osd_rgb for coordinate (x,y) is valid exactly 2 clk after x,y are presented. x[2:0] is delayed 2 stages, y[3:0] 1 stage, RAM output 1 stage.
REQ-020 Font bit = font_word[7 - x_d2[2:0]]. rev = ch_d1[7] XOR cursor_hit. The pixel shows the foreground color if font_bit XOR rev, else the background color.
REQ-021 Transparency: osd_rgb = KEY_COLOR when ch_d1[6:0] = 0 and cursor_hit = 0.
REQ-022 cursor_hit = cur_en AND blink_phase AND (logical col, logical row) = (xc, yc), registered 1 stage to align with ch_d1. A cursor cell on NULL_CHAR therefore shows a solid front_rgb block.
REQ-023 Blink counter: free-running BLINK_W-bit wrap-around counter; blink_phase = MSB.
REQ-024 Writes: if we_ch and FSM is IDLE and no command is accepted that cycle, write ch_in at {(yt + scroll_reg) mod 2^RW, xt}. When busy = 1, we_ch is ignored and the data is dropped.
REQ-025 FSM states: IDLE, CLR_ALL, CLR_ROW. Priority in IDLE: clr_all > scroll_up > we_ch. Losing requests are dropped.
REQ-026 IDLE to CLR_ALL on clr_all. Sweep counter = 0; 0x00 is written at counter address 0 .. 2^(CW+RW)-1, one per cycle, then return to IDLE.
REQ-027 IDLE to CLR_ROW on scroll_up. scroll_reg increments (mod 2^RW) in the acceptance cycle. 0x00 is written to physical row = old scroll_reg, columns 0 .. 2^CW-1, one per cycle, then return to IDLE.
REQ-028 busy is high from the cycle after acceptance through the final sweep write. busy = 0 in the following cycle, and new commands are accepted then. Commands arriving while busy are ignored.
REQ-029 scroll_reg wraps from 2^RW-1 to 0 without error.

Reset
REQ-030 On reset: FSM = IDLE, busy = 0, scroll_reg = 0, blink counter = 0, all delay/pipeline registers = 0.
REQ-031 After reset, osd_rgb = KEY_COLOR until valid RAM data propagates. Tile RAM contents are not reset; software issues clr_all.
REQ-032 Reset asserted mid-sweep aborts the sweep immediately and leaves partially cleared RAM. scroll_reg returns to 0.

Verification
REQ-033 Write 'A' (0x41) at xt=2, yt=1, scroll 0. Scan x=16..23, y=16..31. Output must match font 'A' with front/back colors, 2-cycle latency; neighbouring NULL cells output KEY_COLOR.
REQ-034 clr_all pulse, default params. busy must be high for exactly 4096 cycles; every cell must then read KEY_COLOR; we_ch during busy must have no effect.
REQ-035 Fill row r with char = 0x30+r. Pulse scroll_up. Screen row 0 must show old row 1; bottom row must be blank after 128 busy cycles; scroll_reg = 1.
REQ-036 32 scroll_ups, then write at yt=31. The data must land in physical row 31 (wrap) and display on the bottom row.
REQ-037 cur_en=1, xc=5, yc=3, BLINK_W=4 override. Cell (5,3) must invert colors when MSB=1, be solid front_rgb on NULL, and be normal or transparent when MSB=0.
REQ-038 clr_all and scroll_up and we_ch asserted in the same cycle: only CLR_ALL runs, scroll_reg is unchanged, and the write is dropped. Reset mid-CLR_ALL: busy = 0 the next cycle.
